// File: rtl/leaf_uplink_arbiter.sv
// Round-robin burst arbiter sharing one router input among NUM_PORTS NI uplinks, with credit flow control.
// Optional ARB_HDR_CHECK_EN: drop flits whose routing header is zero and count them on drop_count.
module leaf_uplink_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int HEADER_W  = 6,
  parameter int CREDITS   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          credit_in,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy
`ifdef ARB_HDR_CHECK_EN
  ,
  output logic [7:0]                    drop_count
`endif
);

  localparam int ID_W = $clog2(NUM_PORTS);
  localparam int CW   = $clog2(CREDITS + 1);
  localparam int BW   = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_id_reg, rr_ptr_reg, arb_pick;
  logic              arb_found;
  logic [CW-1:0]     credit_cnt_reg;
  logic [BW-1:0]     burst_cnt_reg;
  logic [DATA_W-1:0] flit [NUM_PORTS];
  logic [DATA_W-1:0] sel_flit;
  logic              sel_valid, has_credit, xfer, fwd, last_beat, drop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign flit[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign sel_flit   = flit[grant_id_reg];
  assign sel_valid  = req_valid[grant_id_reg];
  assign has_credit = (credit_cnt_reg != '0);
  assign last_beat  = (burst_cnt_reg == BW'(MAX_BURST - 1));
  // A handshake in the reset cycle is suppressed entirely.
  assign xfer       = (state_reg == GRANT) && sel_valid && has_credit && !reset;

`ifdef ARB_HDR_CHECK_EN
  assign drop = (sel_flit[DATA_W-1 -: HEADER_W] == '0);
`else
  assign drop = 1'b0;
`endif
  assign fwd = xfer && !drop;

  // Rotating search starting just after the last granted port.
  always_comb begin : arb_search
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_PORTS;
      if (!arb_found && req_valid[idx]) begin
        arb_found = 1'b1;
        arb_pick  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_found && has_credit) state_next = GRANT;
      GRANT:   if (!sel_valid || (xfer && last_beat)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state_reg == GRANT);
    if ((state_reg == GRANT) && has_credit && !reset) req_ready[grant_id_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id_reg   <= '0;
      rr_ptr_reg     <= ID_W'(NUM_PORTS - 1);
      credit_cnt_reg <= CW'(CREDITS);
      burst_cnt_reg  <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
    end else begin
      out_valid <= fwd;
      if (fwd) out_data <= sel_flit;
      if ((state_reg == IDLE) && (state_next == GRANT)) begin
        grant_id_reg  <= arb_pick;
        burst_cnt_reg <= '0;
      end
      if (xfer) burst_cnt_reg <= burst_cnt_reg + BW'(1);
      if ((state_reg == GRANT) && (state_next == IDLE)) rr_ptr_reg <= grant_id_reg;
      // Simultaneous send and return cancel out; returns saturate at CREDITS.
      if (fwd && !credit_in)
        credit_cnt_reg <= credit_cnt_reg - CW'(1);
      else if (credit_in && !fwd && (credit_cnt_reg != CW'(CREDITS)))
        credit_cnt_reg <= credit_cnt_reg + CW'(1);
    end
  end

`ifdef ARB_HDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                                drop_count <= '0;
    else if (xfer && drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Directed bench for leaf_uplink_arbiter: cycle table for credit exhaustion plus hand sequences.
// Define ARB_HDR_CHECK_EN to also exercise header-zero dropping.
module tb_leaf_uplink_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        credit_in = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef ARB_HDR_CHECK_EN
  logic [7:0]  drop_count;
`endif

  int checks = 0;
  int errors = 0;

  leaf_uplink_arbiter dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
    .credit_in(credit_in), .grant_id(grant_id), .busy(busy)
`ifdef ARB_HDR_CHECK_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        cin;
    logic [3:0]  ready;
    logic        ov;
    logic        busy;
    logic [1:0]  gid;
    logic [2:0]  cred;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; credit_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //          valid cin  ready ov busy gid cred dout
    vecs[0]  = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 3'd4, 16'h0000};
    vecs[1]  = '{4'h8, 1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 3'd4, 16'h0000};
    vecs[2]  = '{4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 3'd3, 16'hC101};
    vecs[3]  = '{4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 3'd2, 16'hC102};
    vecs[4]  = '{4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 3'd1, 16'hC103};
    vecs[5]  = '{4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 3'd0, 16'hC104};
    vecs[6]  = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 3'd0, 16'h0000};
    vecs[7]  = '{4'h8, 1'b1, 4'h0, 1'b0, 1'b0, 2'd3, 3'd0, 16'h0000};
    vecs[8]  = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 3'd1, 16'h0000};
    vecs[9]  = '{4'h8, 1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 3'd1, 16'h0000};
    vecs[10] = '{4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 3'd0, 16'hC109};
    vecs[11] = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 3'd0, 16'h0000};
    vecs[12] = '{4'h8, 1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 3'd0, 16'h0000};
    vecs[13] = '{4'h8, 1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 3'd1, 16'h0000};
    vecs[14] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 3'd0, 16'hC10D};
    vecs[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 3'd0, 16'h0000};

    // Reset state
    reset_dut();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_credit", 32'(dut.credit_cnt_reg), 32'd4);
    $display("txn reset: ov=%b busy=%b gid=%0d", out_valid, busy, grant_id);

    // Single flit from port 1: one-cycle arbitration, one-cycle output latency
    req_data = {16'h0, 16'h0, 16'h1403, 16'h0};
    req_valid = 4'b0010;
    tick();
    check("a_grant", 32'(grant_id), 32'd1);
    check("a_busy", 32'(busy), 32'd1);
    check("a_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    check("a_out_valid", 32'(out_valid), 32'd1);
    check("a_out_data", 32'(out_data), 32'h1403);
    check("a_credit", 32'(dut.credit_cnt_reg), 32'd3);
    $display("txn single: data=%h ov=%b", out_data, out_valid);

    // Credit exhaustion on port 3, cycle by cycle
    reset_dut();
    for (int r = 0; r < 16; r++) begin
      req_valid = vecs[r].valid;
      credit_in = vecs[r].cin;
      req_data  = {16'hC100 + 16'(r), 48'h0};
      #1;
      check($sformatf("v%0d_ready", r), 32'(req_ready), 32'(vecs[r].ready));
      check($sformatf("v%0d_ov", r), 32'(out_valid), 32'(vecs[r].ov));
      check($sformatf("v%0d_busy", r), 32'(busy), 32'(vecs[r].busy));
      check($sformatf("v%0d_gid", r), 32'(grant_id), 32'(vecs[r].gid));
      check($sformatf("v%0d_cred", r), 32'(dut.credit_cnt_reg), 32'(vecs[r].cred));
      if (vecs[r].ov) check($sformatf("v%0d_data", r), 32'(out_data), 32'(vecs[r].dout));
      $display("vec %0d: valid=%h cin=%b ready=%h ov=%b busy=%b data=%h", r,
               req_valid, credit_in, req_ready, out_valid, busy, out_data);
      @(negedge clk);
    end
    req_valid = '0; credit_in = 1'b0;

    // Fairness: ports 0 and 2 continuously valid, credit returned per flit
    reset_dut();
    req_data  = {16'h0, 16'h8822, 16'h0, 16'h4400};
    req_valid = 4'b0101;
    for (int s = 1; s <= 15; s++) begin
      logic exp_ov;
      logic [15:0] exp_d;
      tick();
      exp_ov = !(s == 1 || s == 6 || s == 11);
      exp_d  = (s >= 7 && s <= 10) ? 16'h8822 : 16'h4400;
      check($sformatf("fair%0d_ov", s), 32'(out_valid), 32'(exp_ov));
      if (exp_ov) check($sformatf("fair%0d_data", s), 32'(out_data), 32'(exp_d));
      if (s == 6) check("fair_grant2", 32'(grant_id), 32'd2);
      if (s == 11) check("fair_grant0", 32'(grant_id), 32'd0);
      $display("txn fair %0d: ov=%b data=%h gid=%0d", s, out_valid, out_data, grant_id);
      credit_in = out_valid;
    end
    req_valid = '0; credit_in = 1'b0;

    // Credit arithmetic: send+return cancel, returns saturate
    reset_dut();
    req_data  = {16'h0, 16'h0, 16'h1403, 16'h0};
    req_valid = 4'b0010;
    repeat (3) tick();
    check("c_cred_before", 32'(dut.credit_cnt_reg), 32'd2);
    credit_in = 1'b1;
    tick();
    check("c_send_and_return", 32'(dut.credit_cnt_reg), 32'd2);
    check("c_send_ov", 32'(out_valid), 32'd1);
    req_valid = 4'b0000;
    repeat (2) tick();
    check("c_refilled", 32'(dut.credit_cnt_reg), 32'd4);
    repeat (2) tick();
    check("c_saturate", 32'(dut.credit_cnt_reg), 32'd4);
    check("c_idle", 32'(busy), 32'd0);
    credit_in = 1'b0;
    $display("txn credit: cred=%0d", dut.credit_cnt_reg);

    // Reset during the second flit of a port-2 burst
    reset_dut();
    req_data  = {16'hCC33, 16'h8822, 16'h5511, 16'h4400};
    req_valid = 4'b0100;
    repeat (2) tick();
    check("r_first_flit", 32'(out_data), 32'h8822);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_out_valid", 32'(out_valid), 32'd0);
    check("r_credit", 32'(dut.credit_cnt_reg), 32'd4);
    check("r_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    tick();
    check("r_grant0", 32'(grant_id), 32'd0);
    check("r_busy_again", 32'(busy), 32'd1);
    tick();
    check("r_port0_data", 32'(out_data), 32'h4400);
    check("r_port0_ov", 32'(out_valid), 32'd1);
    req_valid = '0;
    $display("txn reset-abort: gid=%0d data=%h", grant_id, out_data);

`ifdef ARB_HDR_CHECK_EN
    // Header-zero flit is accepted but dropped without spending a credit
    reset_dut();
    req_data  = {48'h0, 16'h0005};
    req_valid = 4'b0001;
    tick();
    check("h_ready", 32'(req_ready), 32'b0001);
    tick();
    check("h_drop_ov", 32'(out_valid), 32'd0);
    check("h_drop_count", 32'(drop_count), 32'd1);
    check("h_drop_credit", 32'(dut.credit_cnt_reg), 32'd4);
    req_data = {48'h0, 16'h8C05};
    tick();
    req_valid = '0;
    check("h_fwd_ov", 32'(out_valid), 32'd1);
    check("h_fwd_data", 32'(out_data), 32'h8C05);
    check("h_fwd_credit", 32'(dut.credit_cnt_reg), 32'd3);
    check("h_fwd_count", 32'(drop_count), 32'd1);
    $display("txn hdr-check: drops=%0d data=%h", drop_count, out_data);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
